// File: rtl/pwla_sigmoid_pipe.sv
// Three-stage piecewise-linear sigmoid with valid/ready handshake.
// Define PWLA_TANH_EN to add a per-sample mode input selecting tanh(x) = 2*sigma(2x) - 1.
module pwla_sigmoid_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef PWLA_TANH_EN
  input  logic              mode,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1) << FRAC_W;
  localparam logic [DATA_W-1:0] BRK_SAT = DATA_W'(5) << FRAC_W;          // 5.0
  localparam logic [DATA_W-1:0] BRK_MID = DATA_W'(19) << (FRAC_W - 3);   // 2.375
  localparam logic [DATA_W-1:0] OFS_HI  = DATA_W'(27) << (FRAC_W - 5);   // 0.84375
  localparam logic [DATA_W-1:0] OFS_MID = DATA_W'(5) << (FRAC_W - 3);    // 0.625
  localparam logic [DATA_W-1:0] OFS_LO  = DATA_W'(1) << (FRAC_W - 1);    // 0.5
  localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic              adv;
  logic              s1_valid_reg, s1_neg_reg;
  logic [DATA_W-1:0] s1_abs_reg;
  logic              s2_valid_reg, s2_neg_reg;
  logic [DATA_W-1:0] s2_y_reg;
  logic [DATA_W-1:0] x_eff, abs_next, y_next, sig_next, res_next;
  logic              neg_next;
`ifdef PWLA_TANH_EN
  logic              s1_mode_reg, s2_mode_reg;
`endif

  // A stalled output freezes the whole pipe; an empty or draining output lets it move.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: optional saturating doubler, then sign and saturating magnitude.
  always_comb begin
    x_eff = in_data;
`ifdef PWLA_TANH_EN
    if (mode) begin
      if (in_data[DATA_W-1] != in_data[DATA_W-2])
        x_eff = in_data[DATA_W-1] ? NEG_MIN : POS_MAX;
      else
        x_eff = {in_data[DATA_W-2:0], 1'b0};
    end
`endif
    neg_next = x_eff[DATA_W-1];
    abs_next = x_eff;
    if (neg_next)
      abs_next = (x_eff == NEG_MIN) ? POS_MAX : (~x_eff + DATA_W'(1));
  end

  // S2: segment select; breakpoints fall into the upper segment.
  always_comb begin
    if (s1_abs_reg >= BRK_SAT)
      y_next = ONE;
    else if (s1_abs_reg >= BRK_MID)
      y_next = (s1_abs_reg >> 5) + OFS_HI;
    else if (s1_abs_reg >= ONE)
      y_next = (s1_abs_reg >> 3) + OFS_MID;
    else
      y_next = (s1_abs_reg >> 2) + OFS_LO;
  end

  // S3: mirror for negative inputs, then optional tanh rescale.
  always_comb begin
    sig_next = s2_neg_reg ? (ONE - s2_y_reg) : s2_y_reg;
    res_next = sig_next;
`ifdef PWLA_TANH_EN
    if (s2_mode_reg)
      res_next = (sig_next << 1) - ONE;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_neg_reg   <= 1'b0;
      s1_abs_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_neg_reg   <= 1'b0;
      s2_y_reg     <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
`ifdef PWLA_TANH_EN
      s1_mode_reg  <= 1'b0;
      s2_mode_reg  <= 1'b0;
`endif
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      s2_valid_reg <= s1_valid_reg;
      out_valid    <= s2_valid_reg;
      if (in_valid) begin
        s1_neg_reg <= neg_next;
        s1_abs_reg <= abs_next;
`ifdef PWLA_TANH_EN
        s1_mode_reg <= mode;
`endif
      end
      if (s1_valid_reg) begin
        s2_neg_reg <= s1_neg_reg;
        s2_y_reg   <= y_next;
`ifdef PWLA_TANH_EN
        s2_mode_reg <= s1_mode_reg;
`endif
      end
      // Data only moves with a valid sample so an idle output keeps its last value.
      if (s2_valid_reg)
        out_data <= res_next;
    end
  end

endmodule

// File: tb/tb_pwla_sigmoid_pipe.sv
// Directed and streaming checks for pwla_sigmoid_pipe (DATA_W=16, FRAC_W=10).
module tb_pwla_sigmoid_pipe;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
`ifdef PWLA_TANH_EN
  logic          mode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwla_sigmoid_pipe #(.DATA_W(16), .FRAC_W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef PWLA_TANH_EN
    .mode     (mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic drive(input int x, input bit m);
    in_data = DW'(x);
`ifdef PWLA_TANH_EN
    mode = m;
`endif
  endtask

  // Reference sigmoid/tanh built from the segment table.
  function automatic logic [DW-1:0] ref_f(input int x, input bit m);
    int xe, a, y, s;
    xe = m ? 2 * x : x;
    if (xe > 32767) xe = 32767;
    if (xe < -32768) xe = -32768;
    a = (xe < 0) ? -xe : xe;
    if (a > 32767) a = 32767;
    if (a >= 5120)      y = 1024;
    else if (a >= 2432) y = a / 32 + 864;
    else if (a >= 1024) y = a / 8 + 640;
    else                y = a / 4 + 512;
    s = (xe < 0) ? 1024 - y : y;
    if (m) s = 2 * s - 1024;
    return DW'(s);
  endfunction

  // One sample into an empty pipe; result must appear on the third edge after acceptance.
  task automatic run_one(input string tag, input int x, input bit m, input int exp);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(x, m);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, DW'(out_valid), DW'(0));
    @(negedge clk);
    check({tag, "_lat2"}, DW'(out_valid), DW'(0));
    @(negedge clk);
    check({tag, "_valid"}, DW'(out_valid), DW'(1));
    check(tag, out_data, DW'(exp));
    $display("txn %s x=%0d mode=%0d y=%0d", tag, x, m, $signed(out_data));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs[100];
    bit ms[8];
    bit pat[4];
    logic [DW-1:0] q[$];
    logic [DW-1:0] held;
    logic [DW-1:0] r;
    bit held_v, ordy;
    int sent, rcvd;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data", out_data, DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Segment points and negative inputs
    run_one("x0",      0,      1'b0, 512);
    run_one("x1024",   1024,   1'b0, 768);
    run_one("x2432",   2432,   1'b0, 940);
    run_one("x5120",   5120,   1'b0, 1024);
    run_one("x6000",   6000,   1'b0, 1024);
    run_one("xm1024",  -1024,  1'b0, 256);
    run_one("xm2432",  -2432,  1'b0, 84);
    run_one("xm32768", -32768, 1'b0, 0);

    // Asynchronous reset with three samples in flight
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(1000, 1'b0);
    @(negedge clk);
    drive(2000, 1'b0);
    @(negedge clk);
    drive(3000, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("inflight_valid", DW'(out_valid), DW'(1));
    rst = 1'b1;
    #1;
    check("midrst_out_valid", DW'(out_valid), DW'(0));
    check("midrst_out_data", out_data, DW'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_no_stale", DW'(out_valid), DW'(0));
      check("postrst_data", out_data, DW'(0));
    end

    // Backpressure: out_ready pattern 1,0,0,1
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    xs[0] = 100;  xs[1] = -300; xs[2] = 1500;  xs[3] = -2500;
    xs[4] = 4000; xs[5] = -6000; xs[6] = 2431; xs[7] = -1023;
    sent = 0; rcvd = 0; held_v = 1'b0; held = '0;
    for (int cyc = 0; cyc < 200 && rcvd < 8; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        check("stall_hold_valid", DW'(out_valid), DW'(1));
        check("stall_hold_data", out_data, held);
      end
      ordy      = pat[cyc % 4];
      out_ready = ordy;
      in_valid  = (sent < 8);
      if (sent < 8) drive(xs[sent], 1'b0);
      #1;
      check("in_ready_adv", DW'(in_ready), DW'(!out_valid || ordy));
      if (out_valid && ordy) begin
        check("bp_data", out_data, q.pop_front());
        $display("txn bp y=%0d", $signed(out_data));
        rcvd++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_f(xs[sent], 1'b0));
        sent++;
      end
      held_v = out_valid && !ordy;
      held   = out_data;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", DW'(rcvd), DW'(8));
    repeat (3) begin
      @(negedge clk);
      check("bp_no_dup", DW'(out_valid), DW'(0));
    end

    // Full throughput with random inputs plus edge values
    for (int i = 0; i < 100; i++) begin
      r = DW'($urandom);
      xs[i] = int'($signed(r));
    end
    xs[0] = -32768; xs[1] = 5119; xs[2] = 5120; xs[3] = 2431; xs[4] = -1024; xs[5] = 32767;
    for (int c = 0; c < 103; c++) begin
      @(negedge clk);
      if (c < 3) begin
        check("tp_fill", DW'(out_valid), DW'(0));
      end else begin
        check("tp_valid", DW'(out_valid), DW'(1));
        check("tp_data", out_data, ref_f(xs[c-3], 1'b0));
        $display("txn tp x=%0d y=%0d", xs[c-3], $signed(out_data));
      end
      check("tp_in_ready", DW'(in_ready), DW'(1));
      in_valid = (c < 100);
      if (c < 100) drive(xs[c], 1'b0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("tp_drained", DW'(out_valid), DW'(0));

`ifdef PWLA_TANH_EN
    run_one("tanh512",   512,   1'b1, 512);
    run_one("tanh0",     0,     1'b1, 0);
    run_one("tanhm512",  -512,  1'b1, -512);
    run_one("tanh20000", 20000, 1'b1, 1024);

    // Mode interleaved per sample
    xs[0] = 512; xs[1] = 512; xs[2] = -1024; xs[3] = -1024; xs[4] = 2432; xs[5] = 2432;
    ms = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        check("mix_valid", DW'(out_valid), DW'(1));
        check("mix_data", out_data, ref_f(xs[c-3], ms[c-3]));
        $display("txn mix x=%0d mode=%0d y=%0d", xs[c-3], ms[c-3], $signed(out_data));
      end
      in_valid = (c < 6);
      if (c < 6) drive(xs[c], ms[c]);
    end
    in_valid = 1'b0;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
